// File: rtl/uart_dtm_host_framer_if.sv
// Request, UART byte and response signals between the host-side DTM framer and its neighbours.
// The slave modport is the framer; the master modport is the host/UART environment.
interface uart_dtm_host_framer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_cmd_i;
    logic [4:0]  req_addr_i;
    logic [40:0] req_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rsp_valid_o;
    logic [33:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_cmd_i, req_addr_i, req_data_i, tx_ready_i, rx_data_i, rx_valid_i,
        output req_ready_o, tx_data_o, tx_valid_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o
    );

    modport master (
        output req_valid_i, req_cmd_i, req_addr_i, req_data_i, tx_ready_i, rx_data_i, rx_valid_i,
        input  req_ready_o, tx_data_o, tx_valid_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o
    );
endinterface

// File: rtl/uart_dtm_host_framer.sv
// Host-side UART debug transport initiator: frames one request as SOF, cmd/addr and
// little-endian payload bytes, then gathers the little-endian response with a timeout.
module uart_dtm_host_framer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    uart_dtm_host_framer_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_CMD    = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_RSP    = 3'd4;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_RW    = 3'b011;
    localparam logic [4:0] ADDR_DMI  = 5'b10001;
    localparam int         CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_r, state_nxt_s;
    logic [2:0]    idx_r, idx_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]    cmd_r;
    logic [4:0]    addr_r;
    logic [40:0]   data_r;
    logic [33:0]   rsp_data_r;
    logic [7:0]    tx_data_r, tx_byte_nxt_s;
    logic          tx_valid_r, req_ready_r, busy_r, rsp_valid_r, rsp_timeout_r;
    logic          accept_s, tx_fire_s, is_dmi_s, rsp_done_s, rsp_tmo_s;
    logic [2:0]    tx_last_s, rx_last_s;

    // Payload byte idx of the 48-bit little-endian image; bits above 40 are sent as zero.
    function automatic logic [7:0] payload_byte(input logic [40:0] data, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = data[7:0];
            3'd1:    b = data[15:8];
            3'd2:    b = data[23:16];
            3'd3:    b = data[31:24];
            3'd4:    b = data[39:32];
            3'd5:    b = {7'b0000000, data[40]};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept_s  = bus.req_valid_i & req_ready_r;
    assign tx_fire_s = tx_valid_r & bus.tx_ready_i;
    assign is_dmi_s  = (addr_r == ADDR_DMI);
    assign tx_last_s = is_dmi_s ? 3'd5 : 3'd3;
    assign rx_last_s = is_dmi_s ? 3'd4 : 3'd3;

    // Next-state, byte index and timeout counter decisions.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        rsp_done_s  = 1'b0;
        rsp_tmo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_HDR;
                    idx_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tx_fire_s) begin
                    state_nxt_s = ST_CMD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_CMD: begin
                if (tx_fire_s) begin
                    idx_nxt_s = 3'd0;
                    cnt_nxt_s = {CW{1'b0}};
                    case (cmd_r)
                        CMD_WRITE: state_nxt_s = ST_DATA;
                        CMD_RW:    state_nxt_s = ST_DATA;
                        CMD_READ:  state_nxt_s = ST_RSP;
                        default:   state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_DATA: begin
                if (tx_fire_s && (idx_r == tx_last_s)) begin
                    idx_nxt_s   = 3'd0;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = (cmd_r == CMD_RW) ? ST_RSP : ST_IDLE;
                end else if (tx_fire_s) begin
                    idx_nxt_s = idx_r + 3'd1;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_RSP: begin
                if (bus.rx_valid_i && (idx_r == rx_last_s)) begin
                    cnt_nxt_s   = {CW{1'b0}};
                    idx_nxt_s   = 3'd0;
                    rsp_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (bus.rx_valid_i) begin
                    cnt_nxt_s = {CW{1'b0}};
                    idx_nxt_s = idx_r + 3'd1;
                end else if (cnt_r == TMO_LAST) begin
                    idx_nxt_s   = 3'd0;
                    rsp_tmo_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        case (state_nxt_s)
            ST_HDR:  tx_byte_nxt_s = 8'h01;
            ST_CMD:  tx_byte_nxt_s = {cmd_r, addr_r};
            ST_DATA: tx_byte_nxt_s = payload_byte(data_r, idx_nxt_s);
            default: tx_byte_nxt_s = 8'h00;
        endcase
    end

    // State and registered handshake/status outputs, all derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            idx_r         <= 3'd0;
            cnt_r         <= {CW{1'b0}};
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            req_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            cnt_r         <= cnt_nxt_s;
            tx_data_r     <= tx_byte_nxt_s;
            tx_valid_r    <= (state_nxt_s == ST_HDR) || (state_nxt_s == ST_CMD) || (state_nxt_s == ST_DATA);
            req_ready_r   <= (state_nxt_s == ST_IDLE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            rsp_valid_r   <= rsp_done_s | rsp_tmo_s;
            rsp_timeout_r <= rsp_tmo_s;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_r  <= 3'd0;
            addr_r <= 5'd0;
            data_r <= 41'd0;
        end else if (accept_s) begin
            cmd_r  <= bus.req_cmd_i;
            addr_r <= bus.req_addr_i;
            data_r <= bus.req_data_i;
        end
    end

    // Response assembly: the first byte clears stale data; a timeout with no bytes reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_r <= 34'd0;
        end else if ((state_r == ST_RSP) && bus.rx_valid_i) begin
            case (idx_r)
                3'd0:    rsp_data_r <= {26'd0, bus.rx_data_i};
                3'd1:    rsp_data_r[15:8]  <= bus.rx_data_i;
                3'd2:    rsp_data_r[23:16] <= bus.rx_data_i;
                3'd3:    rsp_data_r[31:24] <= bus.rx_data_i;
                3'd4:    rsp_data_r[33:32] <= bus.rx_data_i[1:0];
                default: rsp_data_r <= rsp_data_r;
            endcase
        end else if (rsp_tmo_s && (idx_r == 3'd0)) begin
            rsp_data_r <= 34'd0;
        end
    end

    assign bus.req_ready_o   = req_ready_r;
    assign bus.tx_data_o     = tx_data_r;
    assign bus.tx_valid_o    = tx_valid_r;
    assign bus.rsp_valid_o   = rsp_valid_r;
    assign bus.rsp_data_o    = rsp_data_r;
    assign bus.rsp_timeout_o = rsp_timeout_r;
    assign bus.busy_o        = busy_r;
endmodule

// File: tb/tb_uart_dtm_host_framer.sv
// Directed plus randomized bench for uart_dtm_host_framer against a byte-list reference model.
module tb_uart_dtm_host_framer;
    localparam int TMO = 16;
    localparam logic [4:0] A_IDCODE = 5'b00001, A_DTMCS = 5'b10000, A_DMI = 5'b10001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_dtm_host_framer_if bus();
    uart_dtm_host_framer #(.TIMEOUT_CYCLES(TMO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

    int checks = 0;
    int failures = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    byte unsigned rx_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: SOF, {cmd,addr}, then LSB-first payload for WRITE/RW.
    task automatic build_frame(input logic [2:0] cmd, input logic [4:0] addr, input logic [40:0] data);
        logic [47:0] pay;
        int n;
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back({cmd, addr});
        if (cmd == 3'd2 || cmd == 3'd3) begin
            n   = (addr == A_DMI) ? 6 : 4;
            pay = (addr == A_DMI) ? {7'd0, data} : {16'd0, data[31:0]};
            for (int i = 0; i < n; i++) exp_q.push_back(8'((pay >> (8 * i)) & 48'hFF));
        end
    endtask

    // mode 0: ready always high, 1: toggling starting high, 2: random
    task automatic run_frame(input logic [2:0] cmd, input logic [4:0] addr, input logic [40:0] data, input int mode);
        int cyc = 0;
        bit stalled = 1'b0;
        bit r;
        logic [7:0] prev = 8'h00;
        bit want_rsp = (cmd == 3'd1 || cmd == 3'd3);
        build_frame(cmd, addr, data);
        got_q.delete();
        @(negedge clk);
        check("req_ready_idle", bus.req_ready_o, 1);
        bus.req_cmd_i = cmd; bus.req_addr_i = addr; bus.req_data_i = data; bus.req_valid_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("hdr_at_t1", {bus.tx_valid_o, bus.tx_data_o}, {1'b1, 8'h01});
        while (bus.tx_valid_o && cyc < 200) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = (cyc % 2 == 0);
            else r = 1'($urandom_range(0, 1));
            if (stalled) check("tx_stable_stall", bus.tx_data_o, prev);
            bus.tx_ready_i = r;
            if (r) got_q.push_back(bus.tx_data_o);
            stalled = !r;
            prev = bus.tx_data_o;
            @(negedge clk);
            cyc++;
        end
        bus.tx_ready_i = 1'b0;
        check("tx_bound", (cyc < 200), 1);
        check("tx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("tx_byte", got_q[i], exp_q[i]);
        if (mode == 0) check("tx_back_to_back", cyc, exp_q.size());
        check("busy_after_tx", bus.busy_o, want_rsp);
        check("ready_after_tx", bus.req_ready_o, !want_rsp);
    endtask

    // Sends rx_q as a full response and checks the single completion pulse.
    task automatic send_rsp(input int gap, input bit dmi);
        logic [63:0] val = 64'd0;
        int g;
        for (int i = 0; i < rx_q.size(); i++) val = val + (64'(rx_q[i]) << (8 * i));
        val = val & (dmi ? 64'h3_FFFF_FFFF : 64'hFFFF_FFFF);
        for (int i = 0; i < rx_q.size(); i++) begin
            bus.rx_data_i = rx_q[i]; bus.rx_valid_i = 1'b1;
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            if (i < rx_q.size() - 1) begin
                check("no_early_rsp", bus.rsp_valid_o, 0);
                g = (gap < 0) ? $urandom_range(0, 4) : gap;
                repeat (g) @(negedge clk);
            end
        end
        check("rsp_valid", bus.rsp_valid_o, 1);
        check("rsp_timeout_clear", bus.rsp_timeout_o, 0);
        check("rsp_data", bus.rsp_data_o, val);
        check("ready_with_rsp", bus.req_ready_o, 1);
        @(negedge clk);
        check("rsp_one_cycle", bus.rsp_valid_o, 0);
    endtask

    initial begin
        int waited;
        logic [2:0] c;
        logic [4:0] a;
        logic [40:0] d;
        bus.req_valid_i = 1'b0; bus.req_cmd_i = 3'd0; bus.req_addr_i = 5'd0; bus.req_data_i = 41'd0;
        bus.tx_ready_i = 1'b0; bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {bus.req_ready_o, bus.tx_valid_o, bus.tx_data_o, bus.rsp_valid_o,
                            bus.rsp_timeout_o, bus.busy_o}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        check("rst_rsp_data", bus.rsp_data_o, 0);
        rst_n = 1'b1;

        run_frame(3'd2, A_DMI, 41'h1_2345_6789_AB, 0);

        run_frame(3'd1, A_IDCODE, 41'd0, 0);
        rx_q = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_rsp(3, 1'b0);

        run_frame(3'd3, A_DMI, 41'h0_DEAD_BEEF_55, 1);
        rx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h03};
        send_rsp(0, 1'b1);

        // rsp_data must survive the next request until its first response byte
        run_frame(3'd1, A_DTMCS, 41'd0, 0);
        check("rsp_data_held", bus.rsp_data_o, 34'h3_1234_5678);
        bus.rx_data_i = 8'h71; bus.rx_valid_i = 1'b1;
        @(negedge clk);
        bus.rx_data_i = 8'h00;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        waited = 1;
        while (!bus.rsp_valid_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_idle_cycles", waited - 1, TMO);
        check("tmo_valid", bus.rsp_valid_o, 1);
        check("tmo_flag", bus.rsp_timeout_o, 1);
        check("tmo_data", bus.rsp_data_o, 34'h71);
        @(negedge clk);
        check("tmo_one_cycle", {bus.rsp_valid_o, bus.rsp_timeout_o}, 2'b00);

        for (int i = 0; i < 3; i++) begin
            bus.rx_data_i = 8'(8'hA0 + i); bus.rx_valid_i = 1'b1;
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            check("stray_rx_idle", {bus.busy_o, bus.rsp_valid_o, bus.tx_valid_o}, 3'b000);
        end
        run_frame(3'd4, 5'd0, 41'h1_FFFF_FFFF_FF, 0);
        run_frame(3'd0, 5'd0, 41'd0, 0);
        repeat (3) @(negedge clk);
        check("ctrl_no_rsp", bus.rsp_valid_o, 0);

        // reset in the middle of a WRITE payload
        bus.req_cmd_i = 3'd2; bus.req_addr_i = A_DMI; bus.req_data_i = 41'h0_1122_3344_55;
        bus.req_valid_i = 1'b1; bus.tx_ready_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", bus.tx_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_txv", bus.tx_valid_o, 0);
        check("rst_async_ready", {bus.req_ready_o, bus.busy_o}, 2'b10);
        bus.tx_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(3'd2, A_IDCODE, 41'h0_0000_CAFE_01, 0);

        for (int t = 0; t < 8; t++) begin
            c = (t % 3 == 0) ? 3'd1 : ((t % 3 == 1) ? 3'd2 : 3'd3);
            a = ($urandom_range(0, 2) == 0) ? A_IDCODE : (($urandom_range(0, 1) == 0) ? A_DTMCS : A_DMI);
            d = {9'($urandom), $urandom};
            run_frame(c, a, d, 2);
            if (c != 3'd2) begin
                rx_q.delete();
                for (int i = 0; i < ((a == A_DMI) ? 5 : 4); i++) rx_q.push_back(8'($urandom));
                send_rsp(-1, a == A_DMI);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
